// File: rtl/unsigned_seq_div_16by8_if.sv
`default_nettype none
// ============================================================================
// Module      : unsigned_seq_div_16by8_if
// Description : Operand/result handshake bundle for the 16/8 sequential divider
// Revision    : 1.0
// ============================================================================
interface unsigned_seq_div_16by8_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [7:0]  r;
  logic        div_by_zero;

  modport master (
    output in_valid, z, y, out_ready,
    input  in_ready, out_valid, q, r, div_by_zero
  );

  modport slave (
    input  in_valid, z, y, out_ready,
    output in_ready, out_valid, q, r, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/unsigned_seq_div_16by8.sv
`default_nettype none
// ============================================================================
// Module      : unsigned_seq_div_16by8
// Description : Restoring radix-2 unsigned 16/8 divider, one quotient bit per
//               clock, with optional skipping of the last TRUNC iterations.
// Revision    : 1.0
// ============================================================================
module unsigned_seq_div_16by8 #(
  parameter int TRUNC = 0
) (
  input wire                      clk,
  input wire                      rst_n,
  unsigned_seq_div_16by8_if.slave bus
);

  localparam int         N_ITER = 16 - TRUNC;
  localparam logic [4:0] N_INIT = 5'(N_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] dvd;
  logic [7:0]  dvs;
  logic [7:0]  rem;
  logic [14:0] quot;
  logic [4:0]  cnt;
  logic [15:0] q_reg;
  logic [7:0]  r_reg;
  logic        dbz;

  logic        accept;
  logic        last;
  logic [8:0]  r9;
  logic        ge;
  logic [7:0]  rem_nxt;
  logic [15:0] q_full;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (state == BUSY) && (cnt == 5'd1);

  // r9 - dvs is always below 256 when ge holds, so an 8-bit subtract is exact.
  assign r9      = {rem, dvd[15]};
  assign ge      = (r9 >= {1'b0, dvs});
  assign rem_nxt = ge ? (r9[7:0] - dvs) : r9[7:0];
  assign q_full  = {quot, ge} << TRUNC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = (bus.y == 8'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == 5'd1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quot  <= '0;
      cnt   <= '0;
      q_reg <= '0;
      r_reg <= '0;
      dbz   <= 1'b0;
    end else if (accept) begin
      dvd  <= bus.z;
      dvs  <= bus.y;
      rem  <= '0;
      quot <= '0;
      dbz  <= 1'b0;
      cnt  <= N_INIT;
      if (bus.y == 8'd0) begin
        cnt   <= '0;
        q_reg <= 16'hFFFF;
        r_reg <= 8'hFF;
        dbz   <= 1'b1;
      end
    end else if (state == BUSY) begin
      dvd  <= {dvd[14:0], 1'b0};
      rem  <= rem_nxt;
      quot <= {quot[13:0], ge};
      cnt  <= cnt - 5'd1;
      // Results are captured only at the final iteration so q/r stay steady in DONE.
      if (last) begin
        q_reg <= q_full;
        r_reg <= rem_nxt;
      end
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.q           = q_reg;
  assign bus.r           = r_reg;
  assign bus.div_by_zero = dbz;

endmodule
`default_nettype wire

// File: tb/tb_unsigned_seq_div_16by8.sv
`default_nettype none
// ============================================================================
// Module      : tb_unsigned_seq_div_16by8
// Description : Table-driven scoreboard bench for the 16/8 divider at TRUNC 0 and 4
// Revision    : 1.0
// ============================================================================
module tb_unsigned_seq_div_16by8;

  typedef struct {
    logic        sel;   // 0: TRUNC=0 instance, 1: TRUNC=4 instance
    logic [15:0] z;
    logic [7:0]  y;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;   // clock edges after the accept edge until out_valid
    int          hold;  // cycles out_ready is held low in DONE
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] z = '0;
  logic [7:0]  y = '0;

  unsigned_seq_div_16by8_if bus0 ();
  unsigned_seq_div_16by8_if bus4 ();

  unsigned_seq_div_16by8 #(.TRUNC(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  unsigned_seq_div_16by8 #(.TRUNC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  assign bus0.in_valid  = in_valid & ~sel;
  assign bus4.in_valid  = in_valid & sel;
  assign bus0.out_ready = out_ready & ~sel;
  assign bus4.out_ready = out_ready & sel;
  assign bus0.z = z;
  assign bus4.z = z;
  assign bus0.y = y;
  assign bus4.y = y;

  logic        s_in_ready, s_out_valid, s_dbz;
  logic [15:0] s_q;
  logic [7:0]  s_r;
  assign s_in_ready  = sel ? bus4.in_ready    : bus0.in_ready;
  assign s_out_valid = sel ? bus4.out_valid   : bus0.out_valid;
  assign s_q         = sel ? bus4.q           : bus0.q;
  assign s_r         = sel ? bus4.r           : bus0.r;
  assign s_dbz       = sel ? bus4.div_by_zero : bus0.div_by_zero;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic vec_t model(input logic s, input logic [15:0] zz, input logic [7:0] yy);
    vec_t v;
    int   t;
    int   zh;
    t      = s ? 4 : 0;
    v.sel  = s;
    v.z    = zz;
    v.y    = yy;
    v.hold = 0;
    if (yy == 8'd0) begin
      v.q = 16'hFFFF; v.r = 8'hFF; v.dbz = 1'b1; v.lat = 0;
    end else begin
      zh    = int'(zz) >> t;
      v.q   = 16'((zh / int'(yy)) << t);
      v.r   = 8'(zh % int'(yy));
      v.dbz = 1'b0;
      v.lat = 16 - t;
    end
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int   lat;
    int   t;
    exp_t e;
    t   = v.sel ? 4 : 0;
    sel = v.sel;
    @(negedge clk);
    chk("in_ready_idle", 32'(s_in_ready), 32'd1);
    z = v.z; y = v.y; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{v.q, v.r, v.dbz, v.lat});
    @(negedge clk);
    in_valid = 1'b0;
    z = 16'($urandom);
    y = 8'($urandom);
    lat = 0;
    while (!s_out_valid && lat < 40) begin
      chk("in_ready_busy", 32'(s_in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    if (!s_out_valid) begin
      chk("out_valid_timeout", 32'(s_out_valid), 32'd1);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("q", 32'(s_q), 32'(e.q));
    chk("r", 32'(s_r), 32'(e.r));
    chk("div_by_zero", 32'(s_dbz), 32'(e.dbz));
    if (v.y != 8'd0)
      chk("identity", 32'(s_q) * 32'(v.y) + (32'(s_r) << t) + (32'(v.z) % (32'd1 << t)), 32'(v.z));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(s_out_valid), 32'd1);
      chk("hold_in_ready", 32'(s_in_ready), 32'd0);
      chk("hold_q", 32'(s_q), 32'(e.q));
      chk("hold_r", 32'(s_r), 32'(e.r));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", 32'(s_out_valid), 32'd0);
    chk("release_in_ready", 32'(s_in_ready), 32'd1);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 16, 0};
    tbl[1] = '{1'b0, 16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 16, 0};
    tbl[2] = '{1'b0, 16'd0,     8'd255, 16'd0,     8'd0,   1'b0, 16, 0};
    tbl[3] = '{1'b0, 16'd254,   8'd255, 16'd0,     8'd254, 1'b0, 16, 0};
    tbl[4] = '{1'b0, 16'd1234,  8'd0,   16'hFFFF,  8'hFF,  1'b1, 0,  2};
    tbl[5] = '{1'b1, 16'd1000,  8'd7,   16'd128,   8'd6,   1'b0, 12, 0};
    tbl[6] = '{1'b1, 16'd65535, 8'd1,   16'd65520, 8'd0,   1'b0, 12, 0};
    tbl[7] = '{1'b1, 16'd1234,  8'd0,   16'hFFFF,  8'hFF,  1'b1, 0,  0};
    tbl[8] = '{1'b0, 16'd26884, 8'd200, 16'd134,   8'd84,  1'b0, 16, 5};
    tbl[9] = '{1'b0, 16'd100,   8'd3,   16'd33,    8'd1,   1'b0, 16, 0};

    repeat (3) @(negedge clk);
    chk("rst_out_valid0", 32'(bus0.out_valid), 32'd0);
    chk("rst_q0", 32'(bus0.q), 32'd0);
    chk("rst_r0", 32'(bus0.r), 32'd0);
    chk("rst_dbz0", 32'(bus0.div_by_zero), 32'd0);
    chk("rst_out_valid4", 32'(bus4.out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready0", 32'(bus0.in_ready), 32'd1);
    chk("rst_in_ready4", 32'(bus4.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_op(tbl[i]);

    for (int i = 0; i < 12; i++)
      run_op(model(i[0], 16'($urandom), 8'($urandom_range(1, 255))));

    // Abort mid-operation: dut0 still shows 33 from an earlier result until reset hits.
    run_op(tbl[9]);
    sel = 1'b0;
    @(negedge clk);
    z = 16'd1000; y = 8'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("abort_q", 32'(bus0.q), 32'd0);
    chk("abort_r", 32'(bus0.r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_no_result", 32'(bus0.out_valid), 32'd0);
    end
    run_op('{1'b0, 16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 16, 0});

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
